fm_disc: RTL and testbench

- Polar-domain post-processor that sits directly downstream of the r2p CORDIC stage and consumes its valid/mag/angle stream.
- Computes the per-sample phase difference, which is the instantaneous frequency with modular wrap. Block-averages the frequency and the magnitude over 2^AVG_LOG2 samples.
- Applies a magnitude squelch with hysteresis. Emits one decimated frequency/magnitude result per block, for FM/tone demod and carrier monitoring.

---
 rtl/fm_disc_pkg.sv | 17 +
 rtl/fm_disc_blk_avg.sv | 56 +++++
 rtl/fm_disc.sv | 104 ++++++++++
 tb/tb_fm_disc.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fm_disc_pkg.sv
// rtl/fm_disc_pkg.sv - shared widths, state type and squelch helper for fm_disc
package fm_disc_pkg;

    localparam int PHASE_W = 16;
    localparam int MAG_W   = 16;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Squelch closes only once the magnitude falls 1/8 below the open level
    function automatic logic [MAG_W-1:0] close_level(input logic [MAG_W-1:0] thr);
        return thr - (thr >> 3);
    endfunction

endpackage

// File: rtl/fm_disc_blk_avg.sv
// rtl/fm_disc_blk_avg.sv - block accumulator/averager over 2^AVG_LOG2 samples
module fm_disc_blk_avg #(
    parameter int W        = 16,
    parameter int AVG_LOG2 = 4,
    parameter bit SIGNED   = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic         done,
    output logic [W-1:0] avg
);

    localparam int AW = W + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);

    logic [AW-1:0] acc;
    logic [AW-1:0] sum;
    logic [CW-1:0] cnt;

    // The average includes the completing sample, so it is formed from acc + din
    generate
        if (SIGNED) begin : g_signed
            assign sum = acc + AW'($signed(din));
            assign avg = W'($signed(sum) >>> AVG_LOG2);
        end else begin : g_unsigned
            assign sum = acc + AW'(din);
            assign avg = W'(sum >> AVG_LOG2);
        end
    endgenerate

    assign done = en && (cnt == LAST);

    // Accumulate accepted samples; restart the block on completion or flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fm_disc.sv
// rtl/fm_disc.sv - phase-difference FM discriminator with block averaging and squelch
module fm_disc
    import fm_disc_pkg::*;
#(
    parameter int AVG_LOG2 = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               valid_in,
    input  logic [MAG_W-1:0]   mag,
    input  logic [PHASE_W-1:0] angle,
    input  logic [MAG_W-1:0]   sq_thresh,
    output logic               valid_out,
    output logic [PHASE_W-1:0] freq_out,
    output logic [MAG_W-1:0]   mag_out,
    output logic               sq_open
);

    state_t             state;
    logic [PHASE_W-1:0] prev_angle;
    logic [PHASE_W-1:0] dphi;
    logic [PHASE_W-1:0] favg;
    logic [MAG_W-1:0]   mavg;
    logic               run_en;
    logic               fdone;
    logic               mdone;
    logic               blk_done;
    logic               open_nxt;

    // Only RUN samples form a difference; clr discards the coincident sample
    assign run_en   = valid_in && !clr && (state == RUN);
    assign dphi     = angle - prev_angle;
    assign blk_done = fdone && mdone;

    fm_disc_blk_avg #(
        .W        (PHASE_W),
        .AVG_LOG2 (AVG_LOG2),
        .SIGNED   (1'b1)
    ) u_freq_avg (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (run_en),
        .din   (dphi),
        .done  (fdone),
        .avg   (favg)
    );

    fm_disc_blk_avg #(
        .W        (MAG_W),
        .AVG_LOG2 (AVG_LOG2),
        .SIGNED   (1'b0)
    ) u_mag_avg (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (run_en),
        .din   (mag),
        .done  (mdone),
        .avg   (mavg)
    );

    // Hysteresis: open at or above threshold, close below the lower level, else hold
    always_comb begin
        open_nxt = sq_open;
        if (mavg >= sq_thresh) begin
            open_nxt = 1'b1;
        end else if (mavg < close_level(sq_thresh)) begin
            open_nxt = 1'b0;
        end
    end

    // Prime/run tracking of the previous phase sample
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= PRIME;
            prev_angle <= '0;
        end else if (clr) begin
            state      <= PRIME;
        end else if (valid_in) begin
            prev_angle <= angle;
            state      <= RUN;
        end
    end

    // Registered block results; held between completion strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out <= 1'b0;
            freq_out  <= '0;
            mag_out   <= '0;
            sq_open   <= 1'b0;
        end else begin
            valid_out <= blk_done;
            if (blk_done) begin
                mag_out  <= mavg;
                sq_open  <= open_nxt;
                freq_out <= open_nxt ? favg : '0;
            end
        end
    end

endmodule

// File: tb/tb_fm_disc.sv
// tb/tb_fm_disc.sv - directed table-driven bench for fm_disc at AVG_LOG2 = 0, 2, 4
module tb_fm_disc;

    logic        clk;
    logic        reset;
    logic        clr;
    logic [2:0]  vin;
    logic [15:0] mag;
    logic [15:0] angle;
    logic [15:0] sq_thresh;
    logic        vo [3];
    logic [15:0] fo [3];
    logic [15:0] mo [3];
    logic        so [3];

    int n_cmp;
    int n_bad;

    typedef struct {
        int ang;
        int mag;
        int thr;
        bit v;
        int f;
        int m;
        bit s;
    } vec_t;

    vec_t tbl [9];

    fm_disc #(.AVG_LOG2(0)) u0 (
        .clk(clk), .reset(reset), .clr(clr), .valid_in(vin[0]), .mag(mag), .angle(angle),
        .sq_thresh(sq_thresh), .valid_out(vo[0]), .freq_out(fo[0]), .mag_out(mo[0]), .sq_open(so[0])
    );
    fm_disc #(.AVG_LOG2(2)) u2 (
        .clk(clk), .reset(reset), .clr(clr), .valid_in(vin[1]), .mag(mag), .angle(angle),
        .sq_thresh(sq_thresh), .valid_out(vo[1]), .freq_out(fo[1]), .mag_out(mo[1]), .sq_open(so[1])
    );
    fm_disc #(.AVG_LOG2(4)) u4 (
        .clk(clk), .reset(reset), .clr(clr), .valid_in(vin[2]), .mag(mag), .angle(angle),
        .sq_thresh(sq_thresh), .valid_out(vo[2]), .freq_out(fo[2]), .mag_out(mo[2]), .sq_open(so[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, $signed(act), $signed(want));
        end
    endtask

    task automatic expect_out(input int s, input string nm, input logic v,
                              input logic [15:0] f, input logic [15:0] m, input logic sq);
        chk({nm, ".valid"}, {15'd0, vo[s]}, {15'd0, v});
        chk({nm, ".freq"},  fo[s], f);
        chk({nm, ".mag"},   mo[s], m);
        chk({nm, ".sq"},    {15'd0, so[s]}, {15'd0, sq});
    endtask

    task automatic send(input int s, input int a, input int m);
        angle  = a[15:0];
        mag    = m[15:0];
        vin[s] = 1'b1;
        tick();
        vin[s] = 1'b0;
    endtask

    task automatic stream(input int gap, input string tag);
        int a [9] = '{1000, 1005, 1011, 1018, 1026, 1016, 1006, 996, 987};
        for (int i = 0; i < 9; i++) begin
            send(1, a[i], 3000);
            if (i == 4)      expect_out(1, {tag, ".blk0"}, 1'b1, 16'd6, 16'd3000, 1'b1);
            else if (i == 8) expect_out(1, {tag, ".blk1"}, 1'b1, -16'sd10, 16'd3000, 1'b1);
            else             chk({tag, ".idle_valid"}, {15'd0, vo[1]}, 16'd0);
            if (gap > 0) begin
                repeat (gap) tick();
                chk({tag, ".gap_valid"}, {15'd0, vo[1]}, 16'd0);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        clr = 1'b0;
        vin = '0;
        mag = '0;
        angle = '0;
        sq_thresh = '0;

        tbl[0] = '{ang:  32000, mag:   100, thr:   100, v: 0, f:     0, m:     0, s: 0};
        tbl[1] = '{ang: -32000, mag:  5000, thr:   100, v: 1, f:  1536, m:  5000, s: 1};
        tbl[2] = '{ang:  31000, mag:  5000, thr:   100, v: 1, f: -2536, m:  5000, s: 1};
        tbl[3] = '{ang:  31500, mag:    50, thr:   100, v: 1, f:     0, m:    50, s: 0};
        tbl[4] = '{ang:  31600, mag:    95, thr:   100, v: 1, f:     0, m:    95, s: 0};
        tbl[5] = '{ang:  31700, mag:   100, thr:   100, v: 1, f:   100, m:   100, s: 1};
        tbl[6] = '{ang:  31650, mag:    90, thr:   100, v: 1, f:   -50, m:    90, s: 1};
        tbl[7] = '{ang: -32768, mag:     0, thr:     0, v: 1, f:  1118, m:     0, s: 1};
        tbl[8] = '{ang:  32767, mag: 65535, thr: 65535, v: 1, f:    -1, m: 65535, s: 1};

        #1 reset = 1'b0;
        repeat (4) tick();
        expect_out(2, "reset4", 1'b0, 16'd0, 16'd0, 1'b0);
        expect_out(0, "reset0", 1'b0, 16'd0, 16'd0, 1'b0);
        reset = 1'b1;
        tick();

        // Prime, then one 16-sample block with a constant step
        sq_thresh = 16'd2000;
        send(2, 100, 20000);
        chk("prime.valid", {15'd0, vo[2]}, 16'd0);
        for (int k = 1; k <= 16; k++) begin
            send(2, 100 + 1311 * k, 20000);
            if (k < 16) chk("blk1.idle_valid", {15'd0, vo[2]}, 16'd0);
        end
        expect_out(2, "blk1", 1'b1, 16'd1311, 16'd20000, 1'b1);
        tick();
        expect_out(2, "blk1.hold", 1'b0, 16'd1311, 16'd20000, 1'b1);

        // Per-sample vectors at AVG_LOG2 = 0 (wrap, squelch, extremes)
        for (int i = 0; i < 9; i++) begin
            sq_thresh = tbl[i].thr[15:0];
            send(0, tbl[i].ang, tbl[i].mag);
            expect_out(0, $sformatf("tbl%0d", i), tbl[i].v, tbl[i].f[15:0], tbl[i].m[15:0], tbl[i].s);
        end

        // Truncation toward minus infinity at AVG_LOG2 = 2
        sq_thresh = 16'd0;
        send(1, 0, 100);
        send(1, -1, 100); send(1, -1, 100); send(1, -1, 100); send(1, -1, 100);
        expect_out(1, "trunc_neg", 1'b1, -16'sd1, 16'd100, 1'b1);
        send(1, 2, 1); send(1, 2, 2); send(1, 2, 3); send(1, 2, 5);
        expect_out(1, "trunc_pos", 1'b1, 16'd0, 16'd2, 1'b1);

        // Block-level squelch hysteresis at AVG_LOG2 = 4
        sq_thresh = 16'd2000;
        begin
            int a = 100 + 1311 * 16;
            int bm [4] = '{1000, 2000, 1800, 1700};
            bit bs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
            for (int b = 0; b < 4; b++) begin
                for (int k = 0; k < 16; k++) begin
                    a += 10;
                    send(2, a, bm[b]);
                end
                expect_out(2, $sformatf("sq_blk%0d", b), 1'b1, bs[b] ? 16'd10 : 16'd0,
                           bm[b][15:0], bs[b]);
            end
        end

        // Back-to-back versus 1/256 rate give the same results
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr.valid", {15'd0, vo[1]}, 16'd0);
        stream(0, "b2b");
        clr = 1'b1;
        tick();
        clr = 1'b0;
        stream(255, "gap");

        // clr on the 10th sample of a block discards it and re-primes
        for (int k = 1; k <= 9; k++) send(2, 30000 + 10 * k, 3000);
        clr = 1'b1;
        send(2, 30100, 3000);
        clr = 1'b0;
        expect_out(2, "clr10", 1'b0, 16'd0, 16'd1700, 1'b0);
        send(2, 5000, 3000);
        chk("clr.prime_valid", {15'd0, vo[2]}, 16'd0);
        for (int k = 1; k <= 16; k++) begin
            send(2, 5000 - 200 * k, 3000);
            if (k < 16) chk("clr.idle_valid", {15'd0, vo[2]}, 16'd0);
        end
        expect_out(2, "clr.blk", 1'b1, -16'sd200, 16'd3000, 1'b1);

        // Reset pulsed mid-block clears outputs and restarts from PRIME
        for (int k = 1; k <= 9; k++) send(2, 1000 + 10 * k, 3000);
        #2 reset = 1'b0;
        #1;
        expect_out(2, "midrst", 1'b0, 16'd0, 16'd0, 1'b0);
        tick();
        reset = 1'b1;
        send(2, 7000, 4000);
        chk("rst.prime_valid", {15'd0, vo[2]}, 16'd0);
        for (int k = 1; k <= 16; k++) begin
            send(2, 7000 + 50 * k, 4000);
            if (k < 16) chk("rst.idle_valid", {15'd0, vo[2]}, 16'd0);
        end
        expect_out(2, "rst.blk", 1'b1, 16'd50, 16'd4000, 1'b1);
        tick();
        chk("rst.blk_one_cycle", {15'd0, vo[2]}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
